// File: rtl/imem_axil_rd_slave.sv
// AXI-lite read-only slave in front of the instruction SRAM: one SRAM read per
// accepted AR beat, responses returned in order through a small FIFO.

module imem_axil_rd_slave_chk #(
  parameter int unsigned RESP_DEPTH = 2,
  parameter int unsigned CW         = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          push_s,
  input logic          pop_s,
  input logic [CW-1:0] count_q
);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    push_s |-> ((count_q < CW'(RESP_DEPTH)) || pop_s));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    pop_s |-> (count_q != {CW{1'b0}}));
endmodule

module imem_axil_rd_slave #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DATA_W     = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned        MEM_WORDS  = 4096,
  parameter int unsigned        RESP_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ARVALID,
  input  logic [ADDR_W-1:0]             ARADDR,
  output logic                          ARREADY,
  output logic                          RVALID,
  output logic [DATA_W-1:0]             RDATA,
  output logic [1:0]                    RRESP,
  input  logic                          RREADY,
  output logic                          sram_en,
  output logic [$clog2(MEM_WORDS)-1:0]  sram_addr,
  input  logic [DATA_W-1:0]             sram_rdata,
  output logic [15:0]                   err_cnt
);
  localparam int unsigned       AW          = $clog2(MEM_WORDS);
  localparam int unsigned       PW          = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned       CW          = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_W-1:0] WIN_BYTES   = ADDR_W'(MEM_WORDS * 8);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RESP_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  logic [ADDR_W-1:0] off_s;
  logic              in_range_s, arready_s, ar_fire_s, r_fire_s, push_s, pop_s;
  logic [CW:0]       occ_s;

  logic [DATA_W-1:0] data_q [RESP_DEPTH];
  logic [DATA_W-1:0] data_d [RESP_DEPTH];
  logic [1:0]        resp_q [RESP_DEPTH];
  logic [1:0]        resp_d [RESP_DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              inflight_q, inflight_d, err_pending_q, err_pending_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  // Occupancy counts the FIFO plus the read still in the SRAM pipe, net of this cycle's pop.
  assign off_s      = ARADDR - BASE_ADDR;
  assign in_range_s = off_s < WIN_BYTES;
  assign occ_s      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, r_fire_s};
  assign arready_s  = occ_s < (CW + 1)'(RESP_DEPTH);
  assign ar_fire_s  = ARVALID & arready_s;
  assign r_fire_s   = RVALID & RREADY;
  assign push_s     = inflight_q;
  assign pop_s      = r_fire_s;

  assign ARREADY   = arready_s;
  assign RVALID    = (count_q != {CW{1'b0}});
  assign RDATA     = RVALID ? data_q[head_q] : {DATA_W{1'b0}};
  assign RRESP     = RVALID ? resp_q[head_q] : RESP_OKAY;
  assign sram_en   = ar_fire_s & in_range_s;
  assign sram_addr = off_s[3 +: AW];
  assign err_cnt   = err_cnt_q;

  always_comb begin
    data_d        = data_q;
    resp_d        = resp_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    err_cnt_d     = err_cnt_q;
    inflight_d    = ar_fire_s;
    err_pending_d = err_pending_q;

    if (ar_fire_s) begin
      err_pending_d = ~in_range_s;
    end else begin
      err_pending_d = err_pending_q;
    end

    // Errored reads never enabled the SRAM, so its output is masked to zero.
    if (push_s) begin
      data_d[tail_q] = err_pending_q ? {DATA_W{1'b0}} : sram_rdata;
      resp_d[tail_q] = err_pending_q ? RESP_SLVERR : RESP_OKAY;
      tail_d         = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      head_d = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase

    if (r_fire_s && (RRESP == RESP_SLVERR) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q        <= '{default: {DATA_W{1'b0}}};
      resp_q        <= '{default: RESP_OKAY};
      head_q        <= {PW{1'b0}};
      tail_q        <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
      inflight_q    <= 1'b0;
      err_pending_q <= 1'b0;
      err_cnt_q     <= 16'h0000;
    end else begin
      data_q        <= data_d;
      resp_q        <= resp_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      err_pending_q <= err_pending_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  imem_axil_rd_slave_chk #(
    .RESP_DEPTH(RESP_DEPTH),
    .CW        (CW)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .push_s (push_s),
    .pop_s  (pop_s),
    .count_q(count_q)
  );
endmodule

// File: tb/tb_imem_axil_rd_slave.sv
// Randomized self-checking bench for imem_axil_rd_slave: a queue-based model of
// outstanding reads predicts handshakes, R beats, SRAM strobes and err_cnt.

module tb_imem_axil_rd_slave;
  localparam int          DEPTH = 2;
  localparam int          WORDS = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ARVALID = 1'b0;
  logic [31:0] ARADDR = 32'h0;
  logic        ARREADY;
  logic        RVALID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RREADY = 1'b0;
  logic        sram_en;
  logic [11:0] sram_addr;
  logic [63:0] sram_rdata = 64'h0;
  logic [15:0] err_cnt;

  imem_axil_rd_slave dut (
    .clk(clk), .rst(rst), .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [WORDS];
  int cyc = 0;
  always @(posedge clk) cyc++;

  // SRAM model: garbage on cycles after an unenabled read so masking is exercised.
  always @(posedge clk) begin
    if (sram_en) sram_rdata <= mem[sram_addr];
    else         sram_rdata <= {$urandom(), $urandom()};
  end

  typedef struct { logic [63:0] data; logic [1:0] resp; int rdy; } beat_t;
  beat_t       exp_q[$];
  logic [63:0] dut_beats[$];
  int          err_model = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        obs_ar, obs_rv, obs_sram_en;
  logic [63:0] obs_rdata;
  logic [1:0]  obs_rresp;
  logic [11:0] obs_sram_addr;
  logic [15:0] obs_err;

  // One clock of stimulus, compared against the outstanding-read model.
  task automatic step(input logic av, input logic [31:0] aa, input logic rr);
    logic [31:0] off;
    logic        inr, exp_ar, exp_rv, rf;
    beat_t       b;
    @(negedge clk);
    ARVALID = av; ARADDR = aa; RREADY = rr;
    #1;
    obs_ar = ARREADY; obs_rv = RVALID; obs_rdata = RDATA; obs_rresp = RRESP;
    obs_sram_en = sram_en; obs_sram_addr = sram_addr; obs_err = err_cnt;
    off    = aa - BASE;
    inr    = off < 32'(WORDS * 8);
    exp_rv = (exp_q.size() != 0) && (exp_q[0].rdy <= cyc);
    rf     = exp_rv && rr;
    exp_ar = (exp_q.size() - (rf ? 1 : 0)) < DEPTH;
    n_checks++;
    if (obs_ar !== exp_ar) begin
      n_fail++; $display("FAIL arready cyc=%0d got=%b exp=%b", cyc, obs_ar, exp_ar);
    end
    n_checks++;
    if (obs_rv !== exp_rv) begin
      n_fail++; $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, obs_rv, exp_rv);
    end
    if (exp_rv) begin
      n_checks++;
      if (obs_rdata !== exp_q[0].data || obs_rresp !== exp_q[0].resp) begin
        n_fail++;
        $display("FAIL rbeat cyc=%0d got=%h/%b exp=%h/%b", cyc, obs_rdata, obs_rresp,
                 exp_q[0].data, exp_q[0].resp);
      end
    end else begin
      n_checks++;
      if (obs_rdata !== 64'h0 || obs_rresp !== 2'b00) begin
        n_fail++; $display("FAIL ridle cyc=%0d got=%h/%b exp=0/00", cyc, obs_rdata, obs_rresp);
      end
    end
    n_checks++;
    if (obs_sram_en !== (av && exp_ar && inr)) begin
      n_fail++; $display("FAIL sram_en cyc=%0d got=%b exp=%b", cyc, obs_sram_en, av && exp_ar && inr);
    end
    if (av && exp_ar && inr) begin
      n_checks++;
      if (obs_sram_addr !== off[14:3]) begin
        n_fail++; $display("FAIL sram_addr cyc=%0d got=%0d exp=%0d", cyc, obs_sram_addr, off[14:3]);
      end
    end
    n_checks++;
    if (obs_err !== 16'(err_model)) begin
      n_fail++; $display("FAIL err_cnt cyc=%0d got=%0d exp=%0d", cyc, obs_err, err_model);
    end
    if (obs_rv === 1'b1 && rr) dut_beats.push_back(obs_rdata);
    if (rf) begin
      if (exp_q[0].resp == 2'b10 && err_model < 65535) err_model++;
      void'(exp_q.pop_front());
    end
    if (av && exp_ar) begin
      b.data = inr ? mem[off[14:3]] : 64'h0;
      b.resp = inr ? 2'b00 : 2'b10;
      b.rdy  = cyc + 2;
      exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ARVALID = 1'b0; RREADY = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    err_model = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0 || sram_en !== 1'b0 || err_cnt !== 16'h0 ||
        RDATA !== 64'h0 || RRESP !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state got ar=%b rv=%b en=%b err=%0d rd=%h rr=%b exp ar=1 rv=0 en=0 err=0 rd=0 rr=00",
               ARREADY, RVALID, sram_en, err_cnt, RDATA, RRESP);
    end
  endtask

  task automatic test_single();
    step(1'b1, 32'h8000_0008, 1'b1);
    n_checks++;
    if (obs_sram_en !== 1'b1 || obs_sram_addr !== 12'd1) begin
      n_fail++; $display("FAIL single_sram got en=%b addr=%0d exp en=1 addr=1", obs_sram_en, obs_sram_addr);
    end
    step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (obs_rv !== 1'b0) begin
      n_fail++; $display("FAIL single_early got rv=%b exp=0", obs_rv);
    end
    step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (obs_rv !== 1'b1 || obs_rdata !== 64'hDEAD_BEEF_0000_0013 || obs_rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL single_beat got rv=%b %h/%b exp rv=1 deadbeef00000013/00", obs_rv, obs_rdata, obs_rresp);
    end
    step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (obs_rv !== 1'b0) begin
      n_fail++; $display("FAIL single_once got rv=%b exp=0", obs_rv);
    end
  endtask

  task automatic test_stream();
    int drops = 0;
    dut_beats.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, BASE + 32'(4 * i), 1'b1);
      if (obs_ar !== 1'b1) drops++;
    end
    drain(3);
    n_checks++;
    if (drops != 0) begin
      n_fail++; $display("FAIL stream_arready got drops=%0d exp=0", drops);
    end
    n_checks++;
    if (dut_beats.size() != 8) begin
      n_fail++; $display("FAIL stream_count got=%0d exp=8", dut_beats.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (dut_beats[k] !== mem[k / 2]) begin
          n_fail++; $display("FAIL stream_word%0d got=%h exp=%h", k, dut_beats[k], mem[k / 2]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          acc = 0;
    logic [63:0] held = 64'h0;
    logic        unstable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, BASE + 32'($urandom_range(0, 32767)), 1'b0);
      if (obs_ar === 1'b1) acc++;
      if (i == 2) held = obs_rdata;
      if (i > 2 && (obs_rv !== 1'b1 || obs_rdata !== held)) unstable = 1'b1;
    end
    n_checks++;
    if (acc != 2) begin
      n_fail++; $display("FAIL bp_accepts got=%0d exp=2", acc);
    end
    n_checks++;
    if (unstable !== 1'b0 || obs_ar !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold got unstable=%b ar=%b exp unstable=0 ar=0", unstable, obs_ar);
    end
    for (int i = 0; i < 6; i++) step(1'b1, BASE + 32'($urandom_range(0, 32767)), 1'b1);
    drain(3);
  endtask

  task automatic test_errors();
    do_reset();
    step(1'b1, 32'h7FFF_FFFC, 1'b1);
    n_checks++;
    if (obs_sram_en !== 1'b0) begin
      n_fail++; $display("FAIL err_low_en got=%b exp=0", obs_sram_en);
    end
    drain(3);
    n_checks++;
    if (obs_err !== 16'd1) begin
      n_fail++; $display("FAIL err_cnt1 got=%0d exp=1", obs_err);
    end
    step(1'b1, BASE + 32'(WORDS * 8), 1'b1);
    n_checks++;
    if (obs_sram_en !== 1'b0) begin
      n_fail++; $display("FAIL err_high_en got=%b exp=0", obs_sram_en);
    end
    drain(3);
    n_checks++;
    if (obs_err !== 16'd2) begin
      n_fail++; $display("FAIL err_cnt2 got=%0d exp=2", obs_err);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom() : BASE + 32'($urandom_range(0, 32767));
      step(1'($urandom_range(0, 1)), a, ($urandom_range(0, 3) != 0));
    end
    drain(4);
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h7000_0000 + 32'(8 * i), 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (obs_rv !== 1'b0 || obs_ar !== 1'b1 || obs_err !== 16'd0) begin
        n_fail++; $display("FAIL midop_reset got rv=%b ar=%b err=%0d exp rv=0 ar=1 err=0", obs_rv, obs_ar, obs_err);
      end
    end
    test_single();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 65534; i++) step(1'b1, 32'h1000_0000 + 32'(i), 1'b1);
    drain(3);
    n_checks++;
    if (obs_err !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_preload got=%h exp=fffe", obs_err);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 32'hFFFF_FFF8, 1'b1);
    drain(3);
    n_checks++;
    if (obs_err !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold got=%h exp=ffff", obs_err);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = {$urandom(), $urandom()};
    mem[1] = 64'hDEAD_BEEF_0000_0013;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_errors();
    test_random();
    test_reset_midop();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
